// File: rtl/pico_bus_pkg.sv
// pico_bus_pkg: shared FSM encoding and bus constants for the pico-to-Wishbone bridge
package pico_bus_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;
    localparam int WB_AW = 30;
endpackage

// File: rtl/pico_timeout_ctr.sv
// pico_timeout_ctr: saturating cycle counter that flags the last allowed cycle of a bus transfer
module pico_timeout_ctr
    import pico_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYCLES);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (reset || i_clr) r_cnt <= '0;
        else if (i_en && r_cnt != TOP) r_cnt <= r_cnt + 1'b1;
    end
    assign o_expire = r_cnt == LAST;
endmodule

// File: rtl/pico_wb_bridge.sv
// pico_wb_bridge: PicoRV32 native bus to Wishbone B4 classic master with timeout and error capture
module pico_wb_bridge
    import pico_bus_pkg::*;
#(
    parameter logic [31:0] ADDR_MASK      = 32'h0FFF_FFFF,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_s_valid,
    output logic             mem_s_ready,
    input  logic [31:0]      mem_s_addr,
    input  logic [31:0]      mem_s_wdata,
    input  logic [3:0]       mem_s_wstrb,
    output logic [31:0]      mem_s_rdata,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    output logic [3:0]       wbm_sel_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    output logic             err_flag,
    output logic [31:0]      err_addr,
    input  logic             err_clear
);
    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic        w_expire;
    logic        w_in_bus;
    assign w_in_bus    = r_state == ST_BUS;
    assign mem_s_ready = r_state == ST_RESP;
    pico_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (!w_in_bus),
        .i_en     (w_in_bus),
        .o_expire (w_expire)
    );
    // err outranks ack, ack outranks a timeout landing on the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            mem_s_rdata <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
            err_flag    <= 1'b0;
            err_addr    <= '0;
        end else begin
            if (err_clear) err_flag <= 1'b0;
            if (r_state == ST_IDLE && mem_s_valid) begin
                r_addr    <= mem_s_addr;
                wbm_adr_o <= WB_AW'((mem_s_addr & ADDR_MASK) >> 2);
                wbm_dat_o <= mem_s_wdata;
                wbm_we_o  <= |mem_s_wstrb;
                wbm_sel_o <= |mem_s_wstrb ? mem_s_wstrb : 4'hF;
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                r_state   <= ST_BUS;
            end else if (w_in_bus && (wbm_err_i || wbm_ack_i || w_expire)) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                r_state   <= ST_RESP;
                if (wbm_err_i || !wbm_ack_i) begin
                    mem_s_rdata <= ERR_RDATA;
                    err_flag    <= 1'b1;
                    if (!err_flag || err_clear) err_addr <= r_addr;
                end else if (!wbm_we_o) begin
                    mem_s_rdata <= wbm_dat_i;
                end
            end else if (r_state != ST_IDLE && !w_in_bus) begin
                r_state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pico_wb_bridge.sv
// tb_pico_wb_bridge: directed vector bench for the pico Wishbone bridge with a scripted slave
module tb_pico_wb_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_s_valid = 1'b0;
    logic        mem_s_ready;
    logic [31:0] mem_s_addr = '0;
    logic [31:0] mem_s_wdata = '0;
    logic [3:0]  mem_s_wstrb = '0;
    logic [31:0] mem_s_rdata;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [29:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        err_flag;
    logic [31:0] err_addr;
    logic        err_clear = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    pico_wb_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_s_valid (mem_s_valid),
        .mem_s_ready (mem_s_ready),
        .mem_s_addr  (mem_s_addr),
        .mem_s_wdata (mem_s_wdata),
        .mem_s_wstrb (mem_s_wstrb),
        .mem_s_rdata (mem_s_rdata),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .err_flag    (err_flag),
        .err_addr    (err_addr),
        .err_clear   (err_clear)
    );
    // ack_at: index of the stb cycle on which the slave answers (-1 = never)
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ack_at;
        logic        ack;
        logic        err;
        logic        clr;
        logic [31:0] sdat;
        logic [29:0] e_adr;
        logic [3:0]  e_sel;
        logic        e_we;
        int          e_stb;
        int          e_lat;
        logic [31:0] e_rdata;
        logic        e_flag;
        logic [31:0] e_eaddr;
    } vec_t;
    vec_t vecs [9];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic run_vec(input int i);
        vec_t v;
        int stb_n, rdy_n, rdy_step;
        logic [31:0] rd, dat;
        logic [29:0] adr;
        logic [3:0]  sel;
        logic        we;
        v = vecs[i];
        stb_n = 0; rdy_n = 0; rdy_step = -1;
        rd = 'x; dat = 'x; adr = 'x; sel = 'x; we = 1'bx;
        @(posedge clk); #1;
        mem_s_valid = 1'b1;
        mem_s_addr  = v.addr;
        mem_s_wdata = v.wdata;
        mem_s_wstrb = v.wstrb;
        err_clear   = v.clr;
        for (int step = 1; step <= 40; step++) begin
            @(posedge clk); #1;
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            if (rdy_step >= 0) mem_s_valid = 1'b0;
            if (wbm_cyc_o && wbm_stb_o) begin
                if (stb_n == 0) begin
                    adr = wbm_adr_o; sel = wbm_sel_o; we = wbm_we_o; dat = wbm_dat_o;
                end
                if (stb_n == v.ack_at) begin
                    wbm_ack_i = v.ack; wbm_err_i = v.err; wbm_dat_i = v.sdat;
                end
                stb_n++;
            end
            if (mem_s_ready) begin
                rdy_n++;
                err_clear = 1'b0;
                if (rdy_step < 0) begin
                    rdy_step = step;
                    rd = mem_s_rdata;
                end
            end
            if (rdy_step >= 0 && step > rdy_step) break;
        end
        mem_s_valid = 1'b0;
        err_clear = 1'b0;
        chk($sformatf("v%0d_adr", i), 32'(adr), 32'(v.e_adr));
        chk($sformatf("v%0d_sel", i), 32'(sel), 32'(v.e_sel));
        chk($sformatf("v%0d_we", i), 32'(we), 32'(v.e_we));
        chk($sformatf("v%0d_dat_o", i), dat, v.wdata);
        chk($sformatf("v%0d_stb_cycles", i), stb_n, v.e_stb);
        chk($sformatf("v%0d_ready_pulses", i), rdy_n, 1);
        chk($sformatf("v%0d_latency", i), rdy_step + 1, v.e_lat);
        chk($sformatf("v%0d_rdata", i), rd, v.e_rdata);
        chk($sformatf("v%0d_err_flag", i), 32'(err_flag), 32'(v.e_flag));
        chk($sformatf("v%0d_err_addr", i), err_addr, v.e_eaddr);
    endtask
    initial begin
        int rdys, stbs;
        vecs[0] = '{32'hC000_0010, 32'h1234_5678, 4'b0011, 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF,
                    30'h4, 4'b0011, 1'b1, 2, 4, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{32'hC000_0020, 32'h0, 4'b0000, 0, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D,
                    30'h8, 4'hF, 1'b0, 1, 3, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[2] = '{32'hC000_0020, 32'h0, 4'b0000, 0, 1'b1, 1'b1, 1'b0, 32'h5555_5555,
                    30'h8, 4'hF, 1'b0, 1, 3, 32'hDEAD_BEEF, 1'b1, 32'hC000_0020};
        vecs[3] = '{32'hC000_0040, 32'h0, 4'b0000, -1, 1'b0, 1'b0, 1'b0, 32'h0,
                    30'h10, 4'hF, 1'b0, 8, 10, 32'hDEAD_BEEF, 1'b1, 32'hC000_0040};
        vecs[4] = '{32'hC000_0050, 32'hA5A5_A5A5, 4'hF, -1, 1'b0, 1'b0, 1'b0, 32'h0,
                    30'h14, 4'hF, 1'b1, 8, 10, 32'hDEAD_BEEF, 1'b1, 32'hC000_0040};
        vecs[5] = '{32'hC000_0054, 32'h0, 4'b0000, 7, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D,
                    30'h15, 4'hF, 1'b0, 8, 10, 32'h0BAD_F00D, 1'b1, 32'hC000_0040};
        vecs[6] = '{32'hC000_0058, 32'h00FF_00FF, 4'b1100, 0, 1'b0, 1'b1, 1'b0, 32'h0,
                    30'h16, 4'b1100, 1'b1, 1, 3, 32'hDEAD_BEEF, 1'b1, 32'hC000_0040};
        vecs[7] = '{32'hC000_0060, 32'h0, 4'b0000, 2, 1'b0, 1'b1, 1'b1, 32'h0,
                    30'h18, 4'hF, 1'b0, 3, 5, 32'hDEAD_BEEF, 1'b1, 32'hC000_0060};
        vecs[8] = '{32'hC000_0080, 32'h0, 4'b0000, 0, 1'b1, 1'b0, 1'b0, 32'h1122_3344,
                    30'h20, 4'hF, 1'b0, 1, 3, 32'h1122_3344, 1'b0, 32'h0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(wbm_cyc_o), 0);
        chk("rst_stb", 32'(wbm_stb_o), 0);
        chk("rst_we", 32'(wbm_we_o), 0);
        chk("rst_adr", 32'(wbm_adr_o), 0);
        chk("rst_dat_o", wbm_dat_o, 0);
        chk("rst_sel", 32'(wbm_sel_o), 0);
        chk("rst_ready", 32'(mem_s_ready), 0);
        chk("rst_rdata", mem_s_rdata, 0);
        chk("rst_err_flag", 32'(err_flag), 0);
        chk("rst_err_addr", err_addr, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) run_vec(i);
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        chk("clear_flag", 32'(err_flag), 0);
        chk("clear_addr_hold", err_addr, 32'hC000_0020);
        for (int i = 3; i < 8; i++) run_vec(i);
        // three requests with valid held high, address advanced as each ready is seen
        @(posedge clk); #1;
        mem_s_valid = 1'b1;
        mem_s_addr = 32'hC000_0100;
        mem_s_wstrb = 4'b0000;
        rdys = 0; stbs = 0;
        for (int step = 1; step <= 12; step++) begin
            @(posedge clk); #1;
            wbm_ack_i = 1'b0;
            if (wbm_cyc_o && wbm_stb_o) begin
                stbs++;
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h100 + 32'(stbs - 1);
            end
            if (mem_s_ready) begin
                chk($sformatf("b2b_ready_step%0d", rdys), step, 2 + 3 * rdys);
                chk($sformatf("b2b_rdata%0d", rdys), mem_s_rdata, 32'h100 + 32'(rdys));
                rdys++;
                if (rdys < 3) mem_s_addr = 32'hC000_0100 + 32'(4 * rdys);
                else mem_s_valid = 1'b0;
            end
        end
        chk("b2b_ready_count", rdys, 3);
        chk("b2b_stb_count", stbs, 3);
        @(posedge clk); #1;
        mem_s_valid = 1'b1;
        mem_s_addr = 32'hC000_0070;
        @(posedge clk); #1;
        chk("rstbus_cyc_before", 32'(wbm_cyc_o), 1);
        reset = 1'b1;
        mem_s_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstbus_cyc", 32'(wbm_cyc_o), 0);
        chk("rstbus_stb", 32'(wbm_stb_o), 0);
        chk("rstbus_ready", 32'(mem_s_ready), 0);
        chk("rstbus_err_flag", 32'(err_flag), 0);
        chk("rstbus_rdata", mem_s_rdata, 0);
        reset = 1'b0;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h7777_7777;
        @(posedge clk); #1;
        wbm_ack_i = 1'b0;
        chk("late_ack_ready", 32'(mem_s_ready), 0);
        chk("late_ack_cyc", 32'(wbm_cyc_o), 0);
        @(posedge clk); #1;
        chk("late_ack_ready2", 32'(mem_s_ready), 0);
        chk("late_ack_rdata", mem_s_rdata, 0);
        run_vec(8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pico_wb_bridge.md
Name: pico_wb_bridge

Overview:
Bridges the PicoRV32 native memory bus to a Wishbone B4 classic master interface.
It sits on mux slave S3 (window 0xC000_0000) in place of the current tied-off ready, so Wishbone peripherals can be attached.
It adds a per-transfer timeout and error capture, so a missing or faulting slave can never hang the CPU.

Parameters:
ADDR_MASK, 32'h0FFF_FFFF, AND-mask applied to pico addr before forming the Wishbone word address
TIMEOUT_CYCLES, 255, max cycles in BUS state without ack/err before forced termination (1..65535)
ERR_RDATA, 32'hDEAD_BEEF, read data returned on err_i or timeout

Ports:
clk  in  1  system clock (clk_p domain)
reset  in  1  synchronous active-high reset
mem_s_valid  in  1  pico request valid
mem_s_ready  out  1  pico response, single-cycle pulse
mem_s_addr  in  32  byte address
mem_s_wdata  in  32  write data
mem_s_wstrb  in  4  byte strobes; 0 = read
mem_s_rdata  out  32  read data, valid while mem_s_ready=1
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  write enable
wbm_adr_o  out  30  word address = (mem_s_addr & ADDR_MASK)[31:2]
wbm_dat_o  out  32  write data
wbm_sel_o  out  4  byte selects
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  normal termination
wbm_err_i  in  1  error termination
err_flag  out  1  sticky; set on err_i or timeout
err_addr  out  32  mem_s_addr of the first failing transfer since the last clear
err_clear  in  1  clears err_flag; err_addr holds its value

Behaviour:
- Reset (sync, active-high): state=IDLE; all outputs 0, including cyc/stb/we/adr/dat_o/sel/ready/rdata/err_flag/err_addr; timeout counter 0. Reset wins over every other event.
- Reset during BUS: cyc/stb drop at the next edge. No ready is issued. The Wishbone slave sees the cycle aborted.
- FSM states: IDLE, BUS, RESP.
- IDLE, mem_s_valid=1:
  - register adr, dat_o=wdata, we=|wstrb;
  - sel=wstrb for writes, 4'hF for reads;
  - cyc=stb=1; counter=0; go to BUS.
  - Wishbone starts 1 cycle after valid.
- BUS: cyc/stb/adr/dat/sel/we held stable; counter increments each cycle.
  - wbm_err_i=1 (priority over ack when both are high): rdata=ERR_RDATA; set err_flag; record err_addr if err_flag was 0; cyc=stb=0; go to RESP.
  - wbm_ack_i=1 and no err: rdata=wbm_dat_i for reads, unchanged for writes; cyc=stb=0; go to RESP.
  - counter==TIMEOUT_CYCLES-1 with no ack/err: handled as err (ERR_RDATA, flag, address); cyc=stb=0; go to RESP.
  - Acks arriving after cyc drops are ignored.
- RESP: mem_s_ready=1 for exactly one cycle, then go to IDLE. rdata holds until the next response.
- Latency: slave acking in its first stb cycle gives ready 3 cycles after valid (valid -> BUS -> RESP). Minimum back-to-back issue interval is 3 cycles.
- The CPU drops or changes valid on the edge where it samples ready, so IDLE's next sample always belongs to a new request. Valid is never re-sampled while in BUS/RESP.
- err_clear and a simultaneous new error: set wins. err_flag=1; err_addr is captured, since the flag was clear-pending.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Decomposition:
- Shared package pico_bus_pkg holds: FSM state encoding (IDLE/BUS/RESP), the default ERR_RDATA constant, and the Wishbone word-address width (30).
- Sub-module pico_timeout_ctr: clear/enable/expire counter parameterised by TIMEOUT_CYCLES. It is reusable by other bus slaves.
- FSM and datapath stay in the top module.

Test Plan:
- Write 0xC000_0010, wdata 0x1234_5678, wstrb 4'b0011; slave acks on the 2nd stb cycle -> adr_o=0x0000_0004, sel=4'b0011, we=1, dat_o=0x1234_5678; single ready pulse; err_flag=0.
- Read 0xC000_0020; slave returns 0xCAFE_F00D with immediate ack -> sel=4'hF, we=0; rdata=0xCAFE_F00D with ready exactly 3 cycles after valid.
- Read with err_i and ack_i asserted together -> rdata=0xDEAD_BEEF, err_flag=1, err_addr=0xC000_0020. Pulse err_clear -> flag 0, err_addr unchanged.
- No slave response, TIMEOUT_CYCLES=8 -> cyc high for exactly 8 cycles, then ready with ERR_RDATA. A second failure at another address leaves err_addr at the first address.
- Back-to-back CPU requests with immediate acks -> each gets one ready pulse; no duplicate Wishbone cycles; 3-cycle spacing.
- Assert reset during BUS -> cyc/stb/ready all 0 the next cycle. A late ack is ignored. A fresh request after reset completes normally.
